// File: rtl/oflow_pe_set_scheduler_if.sv
// Set/PE handshake bundle for oflow_pe_set_scheduler.
// master: scheduler side (drives set_ready, pe_start, pe_en_mask).
// slave : DMA / PE-array side (drives set_valid, pe_done).
interface oflow_pe_set_scheduler_if #(
  parameter int PE_NUM = 24
);
  logic              set_valid;
  logic              set_ready;
  logic              pe_start;
  logic [PE_NUM-1:0] pe_en_mask;
  logic [PE_NUM-1:0] pe_done;

  modport master (
    input  set_valid,
    input  pe_done,
    output set_ready,
    output pe_start,
    output pe_en_mask
  );

  modport slave (
    output set_valid,
    output pe_done,
    input  set_ready,
    input  pe_start,
    input  pe_en_mask
  );
endinterface

// File: rtl/oflow_pe_set_scheduler.sv
// oflow_pe_set_scheduler: walks one frame's bboxes through the PE array in
// sets of up to PE_NUM. Requests a set from DMA, launches the PEs with an
// enable mask, accumulates per-PE done and pulses frame_done at the end.
// Optional build macro PE_TIMEOUT_EN adds a COLLECT watchdog (TIMEOUT_CYCLES)
// that raises a sticky timeout_err and force-completes a stuck set.
module oflow_pe_set_scheduler #(
  parameter int PE_NUM   = 24,
  parameter int REMAIN_W = 10,
  parameter int SET_W    = 6
`ifdef PE_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                           clk,
  input  logic                           reset_N,
  input  logic                           start_frame,
  input  logic [REMAIN_W-1:0]            num_of_bbox_in_frame,
  oflow_pe_set_scheduler_if.master       pe_bus,
  output logic [SET_W-1:0]               set_idx,
  output logic [SET_W-1:0]               num_of_sets,
  output logic [REMAIN_W-1:0]            remain_bboxes,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SET,
    S_DISPATCH,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [REMAIN_W-1:0] remain_q, remain_d;
  logic [SET_W-1:0]    set_idx_q, set_idx_d;
  logic [SET_W-1:0]    num_sets_q, num_sets_d;
  logic [PE_NUM-1:0]   mask_q, mask_d;
  logic [PE_NUM-1:0]   done_acc_q, done_acc_d;
  logic                timeout_q, timeout_d;

  logic [PE_NUM-1:0]   size_mask;
  logic [REMAIN_W-1:0] set_count;
  logic [REMAIN_W:0]   n_plus;
  logic                all_done;
  logic                wd_expire;

  // Mask for the next set: PE i is enabled while i < remaining bboxes,
  // which yields all ones once remain >= PE_NUM.
  for (genvar gi = 0; gi < PE_NUM; gi++) begin : g_size_mask
    assign size_mask[gi] = (remain_q > REMAIN_W'(gi));
  end

  // ceil(n / PE_NUM) computed one bit wider so n + PE_NUM-1 cannot overflow.
  assign n_plus   = {1'b0, num_of_bbox_in_frame} + (REMAIN_W+1)'(PE_NUM - 1);
  assign all_done = ((done_acc_q | pe_bus.pe_done) & mask_q) == mask_q;

  // Number of bboxes retired by the current set (popcount of the mask).
  always_comb begin
    set_count = '0;
    for (int i = 0; i < PE_NUM; i++) begin
      set_count = set_count + REMAIN_W'(mask_q[i]);
    end
  end

`ifdef PE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts COLLECT cycles that end without all PEs done; restarts per set.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_DISPATCH) begin
      cnt_d = '0;
    end else if (state_q == S_COLLECT && !all_done) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (!reset_N) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // The TIMEOUT_CYCLES-th incomplete COLLECT cycle force-completes the set.
  assign wd_expire = (state_q == S_COLLECT) && !all_done &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign wd_expire = 1'b0;
`endif

  // Next-state and datapath updates; everything holds unless a state acts on it.
  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    set_idx_d  = set_idx_q;
    num_sets_d = num_sets_q;
    mask_d     = mask_q;
    done_acc_d = done_acc_q;
    timeout_d  = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (start_frame) begin
          remain_d   = num_of_bbox_in_frame;
          set_idx_d  = '0;
          num_sets_d = SET_W'(n_plus / (REMAIN_W+1)'(PE_NUM));
          timeout_d  = 1'b0;
          state_d    = (num_of_bbox_in_frame == '0) ? S_DONE : S_WAIT_SET;
        end
      end
      S_WAIT_SET: begin
        if (pe_bus.set_valid) begin
          mask_d  = size_mask;
          state_d = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        done_acc_d = '0;
        state_d    = S_COLLECT;
      end
      S_COLLECT: begin
        done_acc_d = done_acc_q | (pe_bus.pe_done & mask_q);
        if (all_done || wd_expire) begin
          remain_d = (remain_q > set_count) ? (remain_q - set_count) : '0;
          if (wd_expire) timeout_d = 1'b1;
          if (set_idx_q == (num_sets_q - SET_W'(1))) begin
            state_d = S_DONE;
          end else begin
            set_idx_d = set_idx_q + SET_W'(1);
            state_d   = S_WAIT_SET;
          end
        end
      end
      S_DONE: begin
        mask_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_N) begin
      state_q    <= S_IDLE;
      remain_q   <= '0;
      set_idx_q  <= '0;
      num_sets_q <= '0;
      mask_q     <= '0;
      done_acc_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      set_idx_q  <= set_idx_d;
      num_sets_q <= num_sets_d;
      mask_q     <= mask_d;
      done_acc_q <= done_acc_d;
      timeout_q  <= timeout_d;
    end
  end

  assign pe_bus.set_ready  = (state_q == S_WAIT_SET);
  assign pe_bus.pe_start   = (state_q == S_DISPATCH);
  assign pe_bus.pe_en_mask = mask_q;
  assign frame_done        = (state_q == S_DONE);
  assign busy              = (state_q != S_IDLE);
  assign set_idx           = set_idx_q;
  assign num_of_sets       = num_sets_q;
  assign remain_bboxes     = remain_q;
  assign timeout_err       = timeout_q;

endmodule

// File: tb/tb_oflow_pe_set_scheduler.sv
// Directed bench for oflow_pe_set_scheduler (PE_NUM=24, default build).
// Table of whole-frame vectors plus hand-written corner-case sequences.
module tb_oflow_pe_set_scheduler;
  localparam int PE_NUM   = 24;
  localparam int REMAIN_W = 10;
  localparam int SET_W    = 6;

  logic                clk = 1'b0;
  logic                reset_N;
  logic                start_frame;
  logic [REMAIN_W-1:0] n_in;
  logic [SET_W-1:0]    set_idx;
  logic [SET_W-1:0]    num_of_sets;
  logic [REMAIN_W-1:0] remain_bboxes;
  logic                busy;
  logic                frame_done;
  logic                timeout_err;

  oflow_pe_set_scheduler_if #(.PE_NUM(PE_NUM)) bus ();

  oflow_pe_set_scheduler #(
    .PE_NUM(PE_NUM), .REMAIN_W(REMAIN_W), .SET_W(SET_W)
  ) dut (
    .clk                  (clk),
    .reset_N              (reset_N),
    .start_frame          (start_frame),
    .num_of_bbox_in_frame (n_in),
    .pe_bus               (bus),
    .set_idx              (set_idx),
    .num_of_sets          (num_of_sets),
    .remain_bboxes        (remain_bboxes),
    .busy                 (busy),
    .frame_done           (frame_done),
    .timeout_err          (timeout_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          n;
    int          exp_sets;
    logic [23:0] exp_last_mask;
    int          exp_final_idx;
  } vec_t;

  vec_t vecs[7];

  task automatic wait_pe_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.pe_start) seen = 1'b1;
    end
    chk("pe_start_seen", 32'(seen), 32'd1);
  endtask

  task automatic start(input int n);
    @(negedge clk);
    n_in        = 10'(n);
    start_frame = 1'b1;
    @(negedge clk);
    start_frame = 1'b0;
  endtask

  // Whole frame with set_valid held and PEs done 2 cycles after pe_start.
  task automatic run_frame(input vec_t v);
    int starts = 0;
    int hs = 0;
    int fd = 0;
    int post = 0;
    int cd = -1;
    int cyc = 0;
    logic [23:0] cur_mask = '0;
    logic [23:0] exp_mask;
    bus.set_valid = 1'b1;
    bus.pe_done   = '0;
    start(v.n);
    chk("start_num_sets", 32'(num_of_sets), 32'(v.exp_sets));
    chk("start_remain", 32'(remain_bboxes), 32'(v.n));
    chk("start_busy", 32'(busy), 32'd1);
    while (cyc < 1000 && post < 3) begin
      if (cd > 0) cd--;
      if (cd == 0) begin
        bus.pe_done = cur_mask;
        cd = -1;
      end else begin
        bus.pe_done = '0;
      end
      if (bus.set_ready) hs++;
      if (bus.pe_start) begin
        exp_mask = (starts < v.exp_sets - 1) ? 24'hFFFFFF : v.exp_last_mask;
        chk("set_mask", 32'(bus.pe_en_mask), 32'(exp_mask));
        chk("set_idx", 32'(set_idx), 32'(starts));
        chk("set_remain", 32'(remain_bboxes), 32'(v.n - PE_NUM * starts));
        cur_mask = bus.pe_en_mask;
        cd = 2;
        starts++;
      end
      if (frame_done) begin
        fd++;
        chk("done_remain", 32'(remain_bboxes), 32'd0);
        chk("done_set_idx", 32'(set_idx), 32'(v.exp_final_idx));
      end
      if (fd > 0) post++;
      @(negedge clk);
      cyc++;
    end
    bus.pe_done = '0;
    chk("frame_pe_starts", 32'(starts), 32'(v.exp_sets));
    chk("frame_handshakes", 32'(hs), 32'(v.exp_sets));
    chk("frame_done_pulses", 32'(fd), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_mask", 32'(bus.pe_en_mask), 32'd0);
    chk("end_num_sets", 32'(num_of_sets), 32'(v.exp_sets));
    $display("frame n=%0d sets=%0d pe_starts=%0d handshakes=%0d frame_done=%0d cycles=%0d",
             v.n, v.exp_sets, starts, hs, fd, cyc);
  endtask

  logic [23:0] stag[5];
  bit seen;

  initial begin
    vecs[0] = '{n: 50,   exp_sets: 3,  exp_last_mask: 24'h000003, exp_final_idx: 2};
    vecs[1] = '{n: 0,    exp_sets: 0,  exp_last_mask: 24'h000000, exp_final_idx: 0};
    vecs[2] = '{n: 24,   exp_sets: 1,  exp_last_mask: 24'hFFFFFF, exp_final_idx: 0};
    vecs[3] = '{n: 1,    exp_sets: 1,  exp_last_mask: 24'h000001, exp_final_idx: 0};
    vecs[4] = '{n: 25,   exp_sets: 2,  exp_last_mask: 24'h000001, exp_final_idx: 1};
    vecs[5] = '{n: 48,   exp_sets: 2,  exp_last_mask: 24'hFFFFFF, exp_final_idx: 1};
    vecs[6] = '{n: 1023, exp_sets: 43, exp_last_mask: 24'h007FFF, exp_final_idx: 42};

    stag[0] = 24'h00000F;
    stag[1] = 24'h0000FF;
    stag[2] = 24'h0000FF;
    stag[3] = 24'h7FFF00;
    stag[4] = 24'h800000;

    reset_N       = 1'b0;
    start_frame   = 1'b0;
    n_in          = '0;
    bus.set_valid = 1'b0;
    bus.pe_done   = '0;
    repeat (3) @(negedge clk);
    reset_N = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_set_ready", 32'(bus.set_ready), 32'd0);
    chk("rst_pe_start", 32'(bus.pe_start), 32'd0);
    chk("rst_mask", 32'(bus.pe_en_mask), 32'd0);
    chk("rst_remain", 32'(remain_bboxes), 32'd0);
    chk("rst_num_sets", 32'(num_of_sets), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);

    for (int i = 0; i < 7; i++) run_frame(vecs[i]);

    // n=24, staggered done bits; bit 23 arrives last in cycle k.
    bus.set_valid = 1'b1;
    start(24);
    wait_pe_start(seen);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.pe_done = stag[i];
      chk("stag_set_ready", 32'(bus.set_ready), 32'd0);
      chk("stag_no_done", 32'(frame_done), 32'd0);
    end
    @(negedge clk);
    bus.pe_done = 24'h123456;
    chk("stag_frame_done", 32'(frame_done), 32'd1);
    chk("stag_set_ready_k1", 32'(bus.set_ready), 32'd0);
    chk("stag_remain", 32'(remain_bboxes), 32'd0);
    @(negedge clk);
    bus.pe_done = '0;
    chk("stag_idle", 32'(busy), 32'd0);
    chk("stag_single_pulse", 32'(frame_done), 32'd0);
    $display("stagger n=24 sequence complete");

    // n=5: unmasked done bits only must not complete the set.
    start(5);
    wait_pe_start(seen);
    chk("n5_mask", 32'(bus.pe_en_mask), 32'h00001F);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.pe_done = 24'hFFFFE0;
      chk("n5_no_done", 32'(frame_done), 32'd0);
      chk("n5_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    chk("n5_still_collect", 32'(frame_done | bus.set_ready), 32'd0);
    bus.pe_done = 24'h00001F;
    @(negedge clk);
    bus.pe_done = '0;
    chk("n5_frame_done", 32'(frame_done), 32'd1);
    chk("n5_remain", 32'(remain_bboxes), 32'd0);
    @(negedge clk);
    $display("unmasked-done n=5 sequence complete");

    // Second start in WAIT_SET ignored; reset mid-COLLECT aborts.
    bus.set_valid = 1'b0;
    start(30);
    chk("ign_set_ready", 32'(bus.set_ready), 32'd1);
    chk("ign_num_sets", 32'(num_of_sets), 32'd2);
    start(100);
    chk("ign_num_sets_after", 32'(num_of_sets), 32'd2);
    chk("ign_remain_after", 32'(remain_bboxes), 32'd30);
    chk("ign_still_wait", 32'(bus.set_ready), 32'd1);
    bus.set_valid = 1'b1;
    @(negedge clk);
    bus.set_valid = 1'b0;
    chk("ign_pe_start", 32'(bus.pe_start), 32'd1);
    chk("ign_mask", 32'(bus.pe_en_mask), 32'hFFFFFF);
    @(negedge clk);
    reset_N     = 1'b0;
    bus.pe_done = 24'h0000FF;
    @(negedge clk);
    reset_N     = 1'b1;
    bus.pe_done = '0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_set_ready", 32'(bus.set_ready), 32'd0);
    chk("abort_pe_start", 32'(bus.pe_start), 32'd0);
    chk("abort_mask", 32'(bus.pe_en_mask), 32'd0);
    chk("abort_set_idx", 32'(set_idx), 32'd0);
    chk("abort_num_sets", 32'(num_of_sets), 32'd0);
    chk("abort_remain", 32'(remain_bboxes), 32'd0);
    chk("abort_frame_done", 32'(frame_done), 32'd0);
    chk("abort_timeout", 32'(timeout_err), 32'd0);
    $display("ignore-start and reset-abort sequence complete");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
